// File: rtl/mem_boot_arbiter_pkg.sv
// Shared definitions for the boot/run memory arbiter: word and address widths,
// default memory depth and the boot phase encoding.
package mem_boot_arbiter_pkg;
    localparam int WORD_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        LOAD,
        CLEAR,
        RUN
    } boot_state_e;
endpackage

// File: rtl/mem_boot_arbiter_boot_sequencer.sv
// Boot sequencer: streams the loader image into memory from address 0, zero-fills
// the remainder, then raises done and stays idle until the next reset.
module boot_sequencer
    import mem_boot_arbiter_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int DW    = WORD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid_i,
    input  logic [DW-1:0] ld_data_i,
    input  logic          ld_last_i,
    output logic          ld_ready_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic [AW-1:0] load_count_o,
    output logic          done_o
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    boot_state_e   state_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] count_q;
    logic          done_q;
    logic          accept;

    // ld_ready is qualified by rst_n so it drops the instant reset asserts
    assign ld_ready_o = rst_n && (state_q == LOAD);
    assign accept     = ld_valid_i && ld_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        ptr_q   <= ptr_q + 1'b1;
                        count_q <= count_q + 1'b1;
                        // A word landing in the top location ends the load, last or not
                        if (ptr_q == LAST_ADDR) begin
                            state_q <= RUN;
                            done_q  <= 1'b1;
                        end else if (ld_last_i) begin
                            state_q <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= RUN;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign we_o         = accept || (state_q == CLEAR);
    assign addr_o       = ptr_q;
    assign wdata_o      = (state_q == CLEAR) ? '0 : ld_data_i;
    assign load_count_o = count_q;
    assign done_o       = done_q;
endmodule

// File: rtl/mem_boot_arbiter.sv
// Memory port owner: boot sequencer during boot, then the CPU with single-cycle
// debug grants interleaved so neither side can starve the other.
module mem_boot_arbiter
    import mem_boot_arbiter_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int DW    = WORD_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid_i,
    input  logic [DW-1:0] ld_data_i,
    input  logic          ld_last_i,
    output logic          ld_ready_o,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic          cpu_we_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_hold_o,
    output logic          cpu_stall_o,
    input  logic          dbg_req_i,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_wdata_i,
    output logic          dbg_gnt_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          boot_done_o,
    output logic [AW-1:0] load_count_o
);
    logic          seqWe;
    logic [AW-1:0] seqAddr;
    logic [DW-1:0] seqWdata;
    logic          bootDone;
    logic          dbgGnt_q;

    boot_sequencer #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_boot_sequencer (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_last_i   (ld_last_i),
        .ld_ready_o  (ld_ready_o),
        .we_o        (seqWe),
        .addr_o      (seqAddr),
        .wdata_o     (seqWdata),
        .load_count_o(load_count_o),
        .done_o      (bootDone)
    );

    // Masking with the current grant forces a CPU cycle after every debug cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbgGnt_q <= 1'b0;
        end else begin
            dbgGnt_q <= dbg_req_i && !dbgGnt_q && bootDone;
        end
    end

    always_comb begin
        mem_we_o    = seqWe;
        mem_addr_o  = seqAddr;
        mem_wdata_o = seqWdata;
        if (bootDone) begin
            if (dbgGnt_q) begin
                mem_we_o    = dbg_we_i;
                mem_addr_o  = dbg_addr_i;
                mem_wdata_o = dbg_wdata_i;
            end else begin
                mem_we_o    = cpu_we_i;
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wdata_i;
            end
        end
    end

    assign cpu_rdata_o = mem_rdata_i;
    assign dbg_rdata_o = mem_rdata_i;
    assign cpu_hold_o  = !bootDone;
    assign boot_done_o = bootDone;
    assign cpu_stall_o = !bootDone || dbgGnt_q;
    assign dbg_gnt_o   = dbgGnt_q;
endmodule
